lsu_ctrl: RTL and testbench

Load/store unit sitting directly upstream of the 2 KB data memory: accepts one load or store per request from the execute stage, converts it into the memory's access protocol (byte address, 4-bit byte mask, write enable, combinational read), and returns the sign- or zero-extended load result.

- Requests the memory cannot serve in one access are split into several sequential accesses:
  - misaligned halfword or word loads;
  - misaligned halfword or word stores.
- Illegal function codes are flagged without touching memory.

---
 rtl/lsu_ctrl_if.sv | 39 +++
 rtl/lsu_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: bundles every bus-side signal of lsu_ctrl.
//   Request  : i_req_valid, o_req_ready, i_req_we, i_req_funct3, i_req_addr, i_req_wdata
//   Response : o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_misaligned (one-cycle pulse)
//   Memory   : o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren, i_mem_rdata (combinational read)
// The i_/o_ prefixes are from lsu_ctrl's point of view. The slave modport is
// lsu_ctrl itself; the master modport is the execute stage plus data memory.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [2:0]        i_req_funct3;
  logic [ADDR_W-1:0] i_req_addr;
  logic [31:0]       i_req_wdata;

  logic              o_rsp_valid;
  logic [31:0]       o_rsp_rdata;
  logic              o_rsp_err;
  logic              o_rsp_misaligned;

  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [3:0]        o_mem_bmask;
  logic              o_mem_wren;
  logic [31:0]       i_mem_rdata;

  modport slave (
    input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_misaligned,
    output o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren
  );

  modport master (
    output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_misaligned,
    input  o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit in front of a 2^ADDR_W-byte data memory.
// Takes one load/store per request, turns it into one or more memory accesses
// (misaligned loads read two words, misaligned stores write byte by byte),
// and returns the sign/zero-extended load result as a one-cycle response.
// Ports:
//   i_clk      rising-edge clock
//   i_reset_n  asynchronous active-low reset
//   bus        lsu_ctrl_if.slave: request, response and memory signals
// Memory outputs depend only on state and latched request registers.
module lsu_ctrl #(
  parameter int ADDR_W = 11
) (
  input  logic      i_clk,
  input  logic      i_reset_n,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, BYTE, RESP} state_t;

  state_t            state_q;
  state_t            state_d;

  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        k_q;      // byte index while splitting a misaligned store
  logic [31:0]       lo_q;     // first word of a misaligned load
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              mis_q;

  logic              accept;
  logic              req_legal;
  logic              req_mis;
  logic [1:0]        last_k;
  logic [31:0]       pair_shifted;

  function automatic logic [31:0] extend_load(input logic [2:0] funct3, input logic [31:0] raw);
    logic [31:0] r;
    case (funct3)
      3'b000:  r = {{24{raw[7]}}, raw[7:0]};
      3'b001:  r = {{16{raw[15]}}, raw[15:0]};
      3'b100:  r = {24'h0, raw[7:0]};
      3'b101:  r = {16'h0, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  // Decode of the incoming request; only meaningful while accepting in IDLE.
  always_comb begin
    case (bus.i_req_funct3)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = !bus.i_req_we;  // unsigned forms exist only for loads
      default:                req_legal = 1'b0;
    endcase
    req_mis = (bus.i_req_funct3[1:0] == 2'b01 && bus.i_req_addr[0]) ||
              (bus.i_req_funct3[1:0] == 2'b10 && bus.i_req_addr[1:0] != 2'b00);
  end

  assign accept = (state_q == IDLE) && bus.i_req_valid;
  assign last_k = (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;

  // Second word of a misaligned load arrives in ACC1; {hi,lo} shifted down to
  // put byte A at bit 0.
  assign pair_shifted = 32'({bus.i_mem_rdata, lo_q} >> {addr_q[1:0], 3'b000});

  // NOTE: every register, including the data-path latches, sits on the
  // asynchronous reset so outputs are defined the instant i_reset_n falls.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      k_q      <= 2'd0;
      lo_q     <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q     <= bus.i_req_we;
            funct3_q <= bus.i_req_funct3;
            addr_q   <= bus.i_req_addr;
            wdata_q  <= bus.i_req_wdata;
            k_q      <= 2'd0;
            rdata_q  <= 32'h0;
            err_q    <= !req_legal;
            mis_q    <= req_legal && req_mis;
          end
        end
        ACC0: begin
          if (!we_q) begin
            if (mis_q) lo_q    <= bus.i_mem_rdata;
            else       rdata_q <= extend_load(funct3_q, bus.i_mem_rdata);
          end
        end
        ACC1:    rdata_q <= extend_load(funct3_q, pair_shifted);
        BYTE:    k_q     <= k_q + 2'd1;
        default: ;
      endcase
    end
  end

  // Next state and all outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d              = state_q;
    bus.o_req_ready      = 1'b0;
    bus.o_rsp_valid      = 1'b0;
    bus.o_rsp_rdata      = 32'h0;
    bus.o_rsp_err        = 1'b0;
    bus.o_rsp_misaligned = 1'b0;
    bus.o_mem_addr       = '0;
    bus.o_mem_wdata      = 32'h0;
    bus.o_mem_bmask      = 4'b1111;
    bus.o_mem_wren       = 1'b0;

    case (state_q)
      IDLE: begin
        bus.o_req_ready = 1'b1;
        if (bus.i_req_valid) begin
          if (!req_legal)                  state_d = RESP;
          else if (req_mis && bus.i_req_we) state_d = BYTE;
          else                             state_d = ACC0;
        end
      end
      ACC0: begin
        if (mis_q) begin
          // Misaligned load: read the word holding byte A.
          bus.o_mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
          state_d        = ACC1;
        end else begin
          bus.o_mem_addr  = addr_q;
          bus.o_mem_wren  = we_q;
          bus.o_mem_wdata = wdata_q;
          case (funct3_q[1:0])
            2'b00:   bus.o_mem_bmask = 4'b0001;
            2'b01:   bus.o_mem_bmask = 4'b0011;
            default: bus.o_mem_bmask = 4'b1111;
          endcase
          state_d = RESP;
        end
      end
      ACC1: begin
        // Next word; the word index wraps from the top of memory to 0.
        bus.o_mem_addr = {addr_q[ADDR_W-1:2] + (ADDR_W-2)'(1), 2'b00};
        state_d        = RESP;
      end
      BYTE: begin
        bus.o_mem_addr  = addr_q + ADDR_W'(k_q);
        bus.o_mem_bmask = 4'b0001;
        bus.o_mem_wren  = 1'b1;
        bus.o_mem_wdata = {24'h0, wdata_q[{k_q, 3'b000} +: 8]};
        if (k_q == last_k) state_d = RESP;
      end
      RESP: begin
        bus.o_rsp_valid      = 1'b1;
        bus.o_rsp_rdata      = rdata_q;
        bus.o_rsp_err        = err_q;
        bus.o_rsp_misaligned = mis_q;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl. A byte-array memory model
// serves the DUT's memory port; a separate byte-level reference memory
// predicts load results, latencies, write counts and final memory contents.
module tb_lsu_ctrl;
  localparam int ADDR_W    = 11;
  localparam int MEM_BYTES = 1 << ADDR_W;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [7:0]        env_mem [MEM_BYTES];   // memory the DUT talks to
  logic [7:0]        ref_mem [MEM_BYTES];   // reference view of memory
  logic [18:0]       poke_q  [$];           // {addr, byte} backdoor writes
  logic [46:0]       wr_log  [$];           // {addr, wdata, bmask} per DUT write
  logic [ADDR_W-1:0] rd_log  [$];           // addresses of DUT read accesses
  int                wr_count = 0;
  logic [ADDR_W-1:0] rd_base;
  logic [31:0]       rd_word;
  logic [31:0]       rd;

  lsu_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
  lsu_ctrl #(.ADDR_W(ADDR_W)) dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational memory read.
  always_comb begin
    rd_base = {bus.o_mem_addr[ADDR_W-1:2], 2'b00};
    rd_word = {env_mem[rd_base + ADDR_W'(3)], env_mem[rd_base + ADDR_W'(2)],
               env_mem[rd_base + ADDR_W'(1)], env_mem[rd_base]};
    if (bus.o_mem_bmask == 4'b1111) bus.i_mem_rdata = rd_word;
    else                            bus.i_mem_rdata = rd_word >> (8 * bus.o_mem_addr[1:0]);
  end

  // Memory writes (DUT port and backdoor).
  always @(posedge clk) begin
    if (poke_q.size() != 0) begin
      env_mem[poke_q[0][18:8]] <= poke_q[0][7:0];
      void'(poke_q.pop_front());
    end
    if (bus.o_mem_wren) begin
      for (int i = 0; i < 4; i++)
        if (bus.o_mem_bmask[i]) env_mem[bus.o_mem_addr + ADDR_W'(i)] <= bus.o_mem_wdata[8*i +: 8];
      wr_count <= wr_count + 1;
      wr_log.push_back({bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_bmask});
    end
  end

  // A busy, non-responding, non-writing cycle is a read access.
  always @(negedge clk)
    if (rst_n && !bus.o_req_ready && !bus.o_rsp_valid && !bus.o_mem_wren)
      rd_log.push_back(bus.o_mem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    ref_mem[a] = d;
    poke_q.push_back({a, d});
  endtask

  task automatic flush_pokes();
    while (poke_q.size() != 0) @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one request, wait for its response, compare against the reference.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                        input logic [31:0] wd, output logic [31:0] got_rdata);
    logic        legal;
    logic        mis;
    int          n;
    int          lat_e;
    int          wr_e;
    int          rd_e;
    logic [31:0] exp_rd;
    int          wr0;
    int          lat;
    int          ready_hi;

    n      = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal  = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis    = legal && ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00));
    exp_rd = 32'h0;
    if (!legal) begin
      lat_e = 1; wr_e = 0; rd_e = 0;
    end else if (we) begin
      for (int i = 0; i < n; i++) ref_mem[a + ADDR_W'(i)] = wd[8*i +: 8];
      lat_e = mis ? n + 1 : 2; wr_e = mis ? n : 1; rd_e = 0;
    end else begin
      for (int i = 0; i < n; i++) exp_rd = exp_rd | (32'(ref_mem[a + ADDR_W'(i)]) << (8*i));
      if (!f3[2] && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd - (32'd1 << (8*n));
      lat_e = mis ? 3 : 2; wr_e = 0; rd_e = mis ? 2 : 1;
    end

    @(negedge clk);
    check("ready_idle", 64'(bus.o_req_ready), 64'd1);
    rd_log.delete();
    wr0 = wr_count;
    bus.i_req_valid  = 1'b1;
    bus.i_req_we     = we;
    bus.i_req_funct3 = f3;
    bus.i_req_addr   = a;
    bus.i_req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.i_req_valid  = 1'b0;
    bus.i_req_we     = 1'($urandom);
    bus.i_req_funct3 = 3'($urandom);
    bus.i_req_addr   = ADDR_W'($urandom);
    bus.i_req_wdata  = $urandom;

    lat = 0; ready_hi = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.o_req_ready) ready_hi++;
    end while (!bus.o_rsp_valid && lat < 12);

    got_rdata = bus.o_rsp_rdata;
    check("latency",    64'(lat),                  64'(lat_e));
    check("rsp_err",    64'(bus.o_rsp_err),        64'(!legal));
    check("rsp_mis",    64'(bus.o_rsp_misaligned), 64'(mis));
    check("rsp_rdata",  64'(bus.o_rsp_rdata),      64'(exp_rd));
    check("busy_ready", 64'(ready_hi),             64'd0);
    check("resp_mem",   64'({bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_bmask, bus.o_mem_wren}),
                        64'({ADDR_W'(0), 32'h0, 4'b1111, 1'b0}));
    check("write_cnt",  64'(wr_count - wr0),       64'(wr_e));
    check("read_cnt",   64'(rd_log.size()),        64'(rd_e));
    @(negedge clk);
    check("pulse_end",  64'({bus.o_rsp_valid, bus.o_req_ready}), 64'b01);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv;
    int diffs;
    logic [ADDR_W-1:0] a;

    rst_n            = 1'b0;
    bus.i_req_valid  = 1'b0;
    bus.i_req_we     = 1'b0;
    bus.i_req_funct3 = 3'b000;
    bus.i_req_addr   = '0;
    bus.i_req_wdata  = 32'h0;

    // Reset values, before any clock edge.
    #3;
    check("rst_ready",  64'(bus.o_req_ready),      64'd1);
    check("rst_rsp",    64'({bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_misaligned}), 64'd0);
    check("rst_rdata",  64'(bus.o_rsp_rdata),      64'd0);
    check("rst_mem",    64'({bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_bmask, bus.o_mem_wren}),
                        64'({ADDR_W'(0), 32'h0, 4'b1111, 1'b0}));

    for (int i = 0; i < MEM_BYTES; i++) poke(ADDR_W'(i), 8'($urandom));
    flush_pokes();
    rst_n = 1'b1;

    // Aligned word load.
    poke(11'h010, 8'hEF); poke(11'h011, 8'hBE); poke(11'h012, 8'hAD); poke(11'h013, 8'hDE);
    flush_pokes();
    do_req(1'b0, 3'b010, 11'h010, 32'h0, rd);
    check("lw_deadbeef", 64'(rd), 64'hDEADBEEF);

    // Byte/half extension.
    poke(11'h010, 8'h00); poke(11'h011, 8'h00); poke(11'h012, 8'hFF); poke(11'h013, 8'h80);
    flush_pokes();
    do_req(1'b0, 3'b000, 11'h013, 32'h0, rd);
    check("lb_sign", 64'(rd), 64'hFFFFFF80);
    do_req(1'b0, 3'b100, 11'h013, 32'h0, rd);
    check("lbu_zero", 64'(rd), 64'h00000080);
    do_req(1'b0, 3'b001, 11'h012, 32'h0, rd);
    check("lh_sign", 64'(rd), 64'hFFFF80FF);

    // Misaligned word store split into four byte writes.
    for (int i = 0; i < 8; i++) poke(ADDR_W'(i), 8'h00);
    flush_pokes();
    wr_log.delete();
    do_req(1'b1, 3'b010, 11'h001, 32'h44332211, rd);
    check("sw_nwrites", 64'(wr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++)
      check("sw_step", 64'(wr_log[i]), 64'({ADDR_W'(i + 1), 32'(8'h11 * (i + 1)), 4'b0001}));
    do_req(1'b0, 3'b010, 11'h000, 32'h0, rd);
    check("lw_0", 64'(rd), 64'h33221100);
    do_req(1'b0, 3'b010, 11'h004, 32'h0, rd);
    check("lw_4", 64'(rd), 64'h00000044);

    // Misaligned half load across the top of memory.
    poke(11'h7FF, 8'h34); poke(11'h000, 8'h92);
    flush_pokes();
    do_req(1'b0, 3'b001, 11'h7FF, 32'h0, rd);
    check("lh_wrap", 64'(rd), 64'hFFFF9234);
    check("lh_wrap_rd0", 64'(rd_log.size() > 0 ? rd_log[0] : ADDR_W'(1)), 64'h7FC);
    check("lh_wrap_rd1", 64'(rd_log.size() > 1 ? rd_log[1] : ADDR_W'(1)), 64'h000);
    do_req(1'b0, 3'b101, 11'h7FF, 32'h0, rd);
    check("lhu_wrap", 64'(rd), 64'h00009234);

    // Illegal function codes.
    do_req(1'b0, 3'b011, 11'h020, 32'h0, rd);
    check("ill_load_rdata", 64'(rd), 64'd0);
    do_req(1'b1, 3'b100, 11'h020, 32'hFFFFFFFF, rd);
    check("ill_store_rdata", 64'(rd), 64'd0);

    // Reset in the middle of a split store (during the third byte).
    for (int i = 0; i < 8; i++) poke(ADDR_W'(i), 8'h00);
    flush_pokes();
    wr_log.delete();
    bus.i_req_valid  = 1'b1;
    bus.i_req_we     = 1'b1;
    bus.i_req_funct3 = 3'b010;
    bus.i_req_addr   = 11'h001;
    bus.i_req_wdata  = 32'h44332211;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out", 64'({bus.o_mem_wren, bus.o_rsp_valid, bus.o_req_ready}), 64'b001);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rv = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_rsp_valid) rv++;
    end
    check("midrst_norsp", 64'(rv), 64'd0);
    check("midrst_nwr",   64'(wr_log.size()), 64'd2);
    check("midrst_b1",    64'(env_mem[1]), 64'h11);
    check("midrst_b2",    64'(env_mem[2]), 64'h22);
    check("midrst_b3",    64'(env_mem[3]), 64'h00);
    check("midrst_b4",    64'(env_mem[4]), 64'h00);
    ref_mem[1] = 8'h11;
    ref_mem[2] = 8'h22;
    do_req(1'b0, 3'b010, 11'h000, 32'h0, rd);
    check("midrst_lw", 64'(rd), 64'h00221100);

    // Randomized traffic, biased toward the memory edges.
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 3))
        0:       a = ADDR_W'($urandom_range(32'h7F8, 32'h7FF));
        1:       a = ADDR_W'($urandom_range(0, 7));
        default: a = ADDR_W'($urandom);
      endcase
      do_req(1'($urandom), 3'($urandom), a, $urandom, rd);
    end

    // Whole memory against the reference.
    diffs = 0;
    for (int i = 0; i < MEM_BYTES; i++)
      if (env_mem[i] !== ref_mem[i]) diffs++;
    check("mem_final_diffs", 64'(diffs), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
